// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: owns the register-file write port.
// It round-robin arbitrates ALU/LSU write-back and keeps a pending-write
// scoreboard for RAW/WAW stalls at issue.
// Optional macro WB_FWD_EN adds same-cycle write-back forwarding outputs
// (qa1_fwd, qa2_fwd, fwd_data).
module regfile_wb_scheduler #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  output logic             alu_ready,
  input  logic             lsu_valid,
  input  logic [4:0]       lsu_rd,
  input  logic [31:0]      lsu_data,
  output logic             lsu_ready,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  output logic             iss_ready,
  input  logic [4:0]       qa1,
  input  logic [4:0]       qa2,
  output logic             qa1_busy,
  output logic             qa2_busy,
`ifdef WB_FWD_EN
  output logic             qa1_fwd,
  output logic             qa2_fwd,
  output logic [31:0]      fwd_data,
`endif
  output logic             WE,
  output logic [4:0]       WA,
  output logic [31:0]      WD,
  output logic [NREGS-1:0] pending,
  output logic             wb_err
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  typedef enum logic {PRIO_ALU, PRIO_LSU} prio_t;

  prio_t            prio;
  logic             wb_fire;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [NREGS-1:0] pending_next;
  logic             iss_fire;

  // Grant selection; reset suppresses both readies so no handshake
  // can complete in a reset cycle.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (alu_valid && (!lsu_valid || prio == PRIO_ALU))
        alu_ready = 1'b1;
      else if (lsu_valid)
        lsu_ready = 1'b1;
    end
  end

  // Mux the winning producer onto the write-back path.
  always_comb begin
    wb_fire = alu_ready | lsu_ready;
    wb_rd   = alu_ready ? alu_rd   : lsu_rd;
    wb_data = alu_ready ? alu_data : lsu_data;
  end

  // Round-robin pointer: after a grant, favour the other producer.
  always_ff @(posedge clk) begin
    if (rst)
      prio <= PRIO_ALU;
    else if (alu_ready)
      prio <= PRIO_LSU;
    else if (lsu_ready)
      prio <= PRIO_ALU;
  end

  // Registered write port; writes to the zero register are dropped and
  // leave WA/WD at their previous values.
  always_ff @(posedge clk) begin
    if (rst) begin
      WE <= 1'b0;
      WA <= '0;
      WD <= '0;
    end else begin
      WE <= 1'b0;
      if (wb_fire && wb_rd != ZR) begin
        WE <= 1'b1;
        WA <= wb_rd;
        WD <= wb_data;
      end
    end
  end

  // Issue gating: a destination already pending is a WAW stall.
  always_comb begin
    iss_ready = (iss_rd == ZR) ? 1'b1 : ~pending[iss_rd];
    iss_fire  = iss_valid & iss_ready & (iss_rd != ZR);
  end

  // Scoreboard next state: clear on the retiring write, set on issue.
  always_comb begin
    pending_next = pending;
    if (WE)
      pending_next[WA] = 1'b0;
    if (iss_fire)
      pending_next[iss_rd] = 1'b1;
  end

  // Scoreboard and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      wb_err  <= 1'b0;
    end else begin
      pending <= pending_next;
      if (WE && !pending[WA])
        wb_err <= 1'b1;
    end
  end

`ifdef WB_FWD_EN
  // Busy queries with forwarding of the write being retired this cycle.
  always_comb begin
    qa1_fwd  = WE && (WA == qa1) && (qa1 != ZR);
    qa2_fwd  = WE && (WA == qa2) && (qa2 != ZR);
    fwd_data = WD;
    qa1_busy = (qa1 != ZR) && pending[qa1] && !qa1_fwd;
    qa2_busy = (qa2 != ZR) && pending[qa2] && !qa2_fwd;
  end
`else
  // Busy queries straight from the scoreboard.
  always_comb begin
    qa1_busy = (qa1 != ZR) && pending[qa1];
    qa2_busy = (qa2 != ZR) && pending[qa2];
  end
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  qa1;
  logic [4:0]  qa2;
  logic        qa1_busy;
  logic        qa2_busy;
`ifdef WB_FWD_EN
  logic        qa1_fwd;
  logic        qa2_fwd;
  logic [31:0] fwd_data;
`endif
  logic        WE;
  logic [4:0]  WA;
  logic [31:0] WD;
  logic [31:0] pending;
  logic        wb_err;

  int n_cmp;
  int n_fail;

  regfile_wb_scheduler #(.NREGS(32), .ZERO_REG(31)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .qa1(qa1), .qa2(qa2), .qa1_busy(qa1_busy), .qa2_busy(qa2_busy),
`ifdef WB_FWD_EN
    .qa1_fwd(qa1_fwd), .qa2_fwd(qa2_fwd), .fwd_data(fwd_data),
`endif
    .WE(WE), .WA(WA), .WD(WD), .pending(pending), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    qa1 = 5'd0; qa2 = 5'd0;
    do_reset();
    n_cmp++; if (WE !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0b exp=0", WE); end
    n_cmp++; if (WA !== 5'd0) begin n_fail++; $display("FAIL reset_wa got=%0d exp=0", WA); end
    n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending got=%h exp=0", pending); end
    n_cmp++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL reset_wb_err got=%0b exp=0", wb_err); end
    n_cmp++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_iss_ready got=%0b exp=1", iss_ready); end
    n_cmp++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got=%0b%0b exp=00", alu_ready, lsu_ready); end
  endtask

  task automatic test_alu_wb();
    iss_valid = 1'b1; iss_rd = 5'd5; #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL alu_iss_ready got=%0b exp=1", iss_ready); end
    tick();
    iss_valid = 1'b0;
    qa1 = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; #1;
    n_cmp++; if (pending !== 32'h0000_0020) begin n_fail++; $display("FAIL alu_pending_set got=%h exp=00000020", pending); end
    n_cmp++; if (qa1_busy !== 1'b1) begin n_fail++; $display("FAIL alu_qa1_busy_pre got=%0b exp=1", qa1_busy); end
    n_cmp++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready got=%0b exp=1", alu_ready); end
    tick();
    alu_valid = 1'b0; #1;
    n_cmp++; if (WE !== 1'b1) begin n_fail++; $display("FAIL alu_we got=%0b exp=1", WE); end
    n_cmp++; if (WA !== 5'd5) begin n_fail++; $display("FAIL alu_wa got=%0d exp=5", WA); end
    n_cmp++; if (WD !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wd got=%h exp=deadbeef", WD); end
`ifdef WB_FWD_EN
    n_cmp++; if (qa1_busy !== 1'b0) begin n_fail++; $display("FAIL alu_qa1_busy_fwd got=%0b exp=0", qa1_busy); end
`else
    n_cmp++; if (qa1_busy !== 1'b1) begin n_fail++; $display("FAIL alu_qa1_busy_wb got=%0b exp=1", qa1_busy); end
`endif
    tick();
    n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL alu_pending_clr got=%h exp=0", pending); end
    n_cmp++; if (qa1_busy !== 1'b0) begin n_fail++; $display("FAIL alu_qa1_busy_post got=%0b exp=0", qa1_busy); end
    n_cmp++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL alu_wb_err got=%0b exp=0", wb_err); end
    n_cmp++; if (WE !== 1'b0) begin n_fail++; $display("FAIL alu_we_drop got=%0b exp=0", WE); end
    qa1 = 5'd0;
  endtask

  task automatic test_arbitration();
    do_reset();
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA0A0_0003;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hB0B0_0007; #1;
    n_cmp++; if (pending !== 32'h0000_0088) begin n_fail++; $display("FAIL arb_pending got=%h exp=00000088", pending); end
    n_cmp++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      n_fail++; $display("FAIL arb_first got=%0b%0b exp=10", alu_ready, lsu_ready); end
    tick();
    n_cmp++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
      n_fail++; $display("FAIL arb_second got=%0b%0b exp=01", alu_ready, lsu_ready); end
    n_cmp++; if (WE !== 1'b1 || WA !== 5'd3 || WD !== 32'hA0A0_0003) begin
      n_fail++; $display("FAIL arb_wb_alu got=%0b/%0d/%h exp=1/3/a0a00003", WE, WA, WD); end
    tick();
    idle_inputs(); #1;
    n_cmp++; if (WE !== 1'b1 || WA !== 5'd7 || WD !== 32'hB0B0_0007) begin
      n_fail++; $display("FAIL arb_wb_lsu got=%0b/%0d/%h exp=1/7/b0b00007", WE, WA, WD); end
    n_cmp++; if (pending !== 32'h0000_0080) begin n_fail++; $display("FAIL arb_pending_mid got=%h exp=00000080", pending); end
    tick();
    n_cmp++; if (pending !== 32'h0 || wb_err !== 1'b0) begin
      n_fail++; $display("FAIL arb_pending_clr got=%h/%0b exp=0/0", pending, wb_err); end
  endtask

  task automatic test_waw();
    iss_valid = 1'b1; iss_rd = 5'd9; #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL waw_first got=%0b exp=1", iss_ready); end
    tick();
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_0099; #1;
    n_cmp++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall got=%0b exp=0", iss_ready); end
    n_cmp++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL waw_lsu_ready got=%0b exp=1", lsu_ready); end
    tick();
    lsu_valid = 1'b0; #1;
    n_cmp++; if (WE !== 1'b1 || WA !== 5'd9) begin n_fail++; $display("FAIL waw_wb got=%0b/%0d exp=1/9", WE, WA); end
    n_cmp++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall_wb got=%0b exp=0", iss_ready); end
    tick();
    n_cmp++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release got=%0b exp=1", iss_ready); end
    tick();
    iss_valid = 1'b0; #1;
    n_cmp++; if (pending !== 32'h0000_0200) begin n_fail++; $display("FAIL waw_reissue got=%h exp=00000200", pending); end
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1;
    tick();
    alu_valid = 1'b0;
    tick();
    n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL waw_clean got=%h exp=0", pending); end
  endtask

  task automatic test_zero_and_err();
    iss_valid = 1'b1; iss_rd = 5'd31;
    qa2 = 5'd31;
    alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 32'h0000_1234; #1;
    n_cmp++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL zero_iss_ready got=%0b exp=1", iss_ready); end
    n_cmp++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_alu_ready got=%0b exp=1", alu_ready); end
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b0; #1;
    n_cmp++; if (WE !== 1'b0) begin n_fail++; $display("FAIL zero_we got=%0b exp=0", WE); end
    n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL zero_pending got=%h exp=0", pending); end
    n_cmp++; if (qa2_busy !== 1'b0) begin n_fail++; $display("FAIL zero_qa2_busy got=%0b exp=0", qa2_busy); end
    qa2 = 5'd0;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h0000_0055;
    tick();
    lsu_valid = 1'b0; #1;
    n_cmp++; if (WE !== 1'b1 || WA !== 5'd12 || WD !== 32'h55) begin
      n_fail++; $display("FAIL err_wb got=%0b/%0d/%h exp=1/12/00000055", WE, WA, WD); end
    n_cmp++; if (wb_err !== 1'b0) begin n_fail++; $display("FAIL err_early got=%0b exp=0", wb_err); end
    tick();
    n_cmp++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL err_set got=%0b exp=1", wb_err); end
    tick();
    tick();
    n_cmp++; if (wb_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%0b exp=1", wb_err); end
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1; iss_rd = 5'd20;
    tick();
    iss_rd = 5'd21;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020_2020;
    tick();
    alu_valid = 1'b0;
    rst = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_data = 32'h2121_2121; #1;
    n_cmp++; if (WE !== 1'b1 || pending !== 32'h0030_0000) begin
      n_fail++; $display("FAIL rstmid_pre got=%0b/%h exp=1/00300000", WE, pending); end
    n_cmp++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got=%0b exp=0", lsu_ready); end
    tick();
    rst = 1'b0;
    lsu_valid = 1'b0; #1;
    n_cmp++; if (WE !== 1'b0 || pending !== 32'h0 || wb_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_post got=%0b/%h/%0b exp=0/0/0", WE, pending, wb_err); end
    tick();
    n_cmp++; if (WE !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard got=%0b exp=0", WE); end
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hCAFE_0004;
    tick();
    alu_valid = 1'b0;
    qa1 = 5'd5; qa2 = 5'd4; #1;
    n_cmp++; if (qa2_busy !== 1'b0 || qa2_fwd !== 1'b1) begin
      n_fail++; $display("FAIL fwd_qa2 got=%0b/%0b exp=0/1", qa2_busy, qa2_fwd); end
    n_cmp++; if (fwd_data !== 32'hCAFE_0004) begin n_fail++; $display("FAIL fwd_data got=%h exp=cafe0004", fwd_data); end
    n_cmp++; if (qa1_fwd !== 1'b0) begin n_fail++; $display("FAIL fwd_qa1 got=%0b exp=0", qa1_fwd); end
    tick();
    n_cmp++; if (qa2_fwd !== 1'b0 || qa2_busy !== 1'b0) begin
      n_fail++; $display("FAIL fwd_after got=%0b/%0b exp=0/0", qa2_fwd, qa2_busy); end
    qa1 = 5'd0; qa2 = 5'd0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    test_reset();
    test_alu_wb();
    test_arbitration();
    test_waw();
    test_zero_and_err();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
